// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-bus controller: bus widths,
// byte-lane enable width and the controller state encoding.
package mem_dbus_ctrl_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int MEM_SEL_W  = 4;

  // Controller states. A 3-bit register is used so CANCEL fits alongside
  // the four primary handshake states.
  typedef enum logic [2:0] {
    MDC_IDLE   = 3'd0,
    MDC_REQ    = 3'd1,
    MDC_DATA   = 3'd2,
    MDC_DONE   = 3'd3,
    MDC_CANCEL = 3'd4
  } mdc_state_e;

endpackage

// File: rtl/mem_store_align.sv
// Store-data lane alignment: shifts right-justified store data up to the
// byte lane selected by the low address bits.
module mem_store_align
  import mem_dbus_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_W
) (
  input  logic [1:0]            byte_off,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  // Shift by whole bytes: offset 0..3 moves the data by 0..24 bits.
  always_comb begin
    data_out = data_in << {byte_off, 3'b000};
  end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-memory access controller. Converts a load/store from
// EX/MEM into an address-phase / data-phase handshake on the data bus,
// stalls the pipeline until the access completes, and presents the raw
// read word to the MEM/WB register.
module mem_dbus_ctrl
  import mem_dbus_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_W,
  parameter int DATA_WIDTH = BUS_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_current_stage,
  input  logic                  flush,
  input  logic                  mem_read_flag_in,
  input  logic                  mem_write_flag_in,
  input  logic [MEM_SEL_W-1:0]  mem_sel_in,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [MEM_SEL_W-1:0]  data_be,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [DATA_WIDTH-1:0] data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_WIDTH-1:0] data_rdata,
  output logic [DATA_WIDTH-1:0] ram_read_data_out,
  output logic                  stall_request
);

  mdc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] wdata_aligned;
  logic                  access;
  logic                  data_done;

  assign access    = mem_read_flag_in | mem_write_flag_in;
  // Read data is valid only when the data phase completes in DATA; a
  // data_ok seen in CANCEL belongs to a killed access.
  assign data_done = (state_q == MDC_DATA) & data_data_ok;

  mem_store_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_store_align (
    .byte_off (address_in[1:0]),
    .data_in  (write_data_in),
    .data_out (wdata_aligned)
  );

  // State and captured read word; both cleared asynchronously so a bus
  // response arriving during reset is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MDC_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic for the two-phase handshake, including flush
  // handling before and after the address phase is accepted.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      MDC_IDLE: begin
        if (access && !flush) begin
          state_d = data_addr_ok ? MDC_DATA : MDC_REQ;
        end
      end
      MDC_REQ: begin
        // Flush before acceptance withdraws the request; nothing is in flight.
        if (flush) begin
          state_d = MDC_IDLE;
        end else if (data_addr_ok) begin
          state_d = MDC_DATA;
        end
      end
      MDC_DATA: begin
        if (data_data_ok) begin
          if (flush) begin
            state_d = MDC_IDLE;
          end else begin
            rdata_d = data_rdata;
            state_d = stall_current_stage ? MDC_DONE : MDC_IDLE;
          end
        end else if (flush) begin
          // Access already accepted by the bus: wait out its data_ok.
          state_d = MDC_CANCEL;
        end
      end
      MDC_DONE: begin
        if (!stall_current_stage) begin
          state_d = MDC_IDLE;
        end
      end
      MDC_CANCEL: begin
        if (data_data_ok) begin
          state_d = MDC_IDLE;
        end
      end
      default: begin
        state_d = MDC_IDLE;
      end
    endcase
  end

  // Bus and pipeline-control outputs; everything is forced low while
  // reset is asserted so the request drops without waiting for a clock.
  always_comb begin
    logic req;
    logic stall;
    req   = 1'b0;
    stall = 1'b0;
    unique case (state_q)
      MDC_IDLE: begin
        req   = access & ~flush;
        stall = access & ~flush;
      end
      MDC_REQ: begin
        req   = ~flush;
        stall = access & ~flush;
      end
      MDC_DATA: begin
        stall = access & ~flush & ~data_data_ok;
      end
      MDC_DONE: begin
        stall = 1'b0;
      end
      MDC_CANCEL: begin
        // A new access must wait until the stale response has drained.
        stall = access;
      end
      default: begin
        req   = 1'b0;
        stall = 1'b0;
      end
    endcase

    data_req          = req & rst;
    stall_request     = stall & rst;
    data_wr           = mem_write_flag_in & rst;
    data_be           = rst ? mem_sel_in : '0;
    data_addr         = rst ? {address_in[ADDR_WIDTH-1:2], 2'b00} : '0;
    data_wdata        = rst ? wdata_aligned : '0;
    ram_read_data_out = data_done ? data_rdata : rdata_q;
  end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed bench for mem_dbus_ctrl: reset, load/store handshakes, lane
// alignment, stall hold, flush in REQ and DATA, and reset mid-access.
module tb_mem_dbus_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_current_stage;
  logic        flush;
  logic        mem_read_flag_in;
  logic        mem_write_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] address_in;
  logic [31:0] write_data_in;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] ram_read_data_out;
  logic        stall_request;

  int total;
  int bad;

  mem_dbus_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_current_stage (stall_current_stage),
    .flush               (flush),
    .mem_read_flag_in    (mem_read_flag_in),
    .mem_write_flag_in   (mem_write_flag_in),
    .mem_sel_in          (mem_sel_in),
    .address_in          (address_in),
    .write_data_in       (write_data_in),
    .data_req            (data_req),
    .data_wr             (data_wr),
    .data_be             (data_be),
    .data_addr           (data_addr),
    .data_wdata          (data_wdata),
    .data_addr_ok        (data_addr_ok),
    .data_data_ok        (data_data_ok),
    .data_rdata          (data_rdata),
    .ram_read_data_out   (ram_read_data_out),
    .stall_request       (stall_request)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait until the sampling point of the current cycle.
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall_current_stage = 1'b0;
    flush               = 1'b0;
    mem_read_flag_in    = 1'b0;
    mem_write_flag_in   = 1'b0;
    mem_sel_in          = 4'h0;
    address_in          = 32'h0;
    write_data_in       = 32'h0;
    data_addr_ok        = 1'b0;
    data_data_ok        = 1'b0;
    data_rdata          = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    mem_read_flag_in = 1'b1;
    mem_sel_in       = 4'hF;
    address_in       = 32'h1234_5678;
    data_data_ok     = 1'b1;
    data_rdata       = 32'hFFFF_FFFF;
    smp();
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b want=0", data_req); end
    total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b want=0", stall_request); end
    total++; if (ram_read_data_out !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=00000000", ram_read_data_out); end
    total++; if (data_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=00000000", data_addr); end
    step();
    step();
    clear_inputs();
    rst = 1'b1;
    smp();
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL rst_rel_req got=%0b want=0", data_req); end
    total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL rst_rel_stall got=%0b want=0", stall_request); end
    total++; if (ram_read_data_out !== 32'h0) begin bad++; $display("FAIL rst_rel_rdata got=%h want=00000000", ram_read_data_out); end
    step();
  endtask

  // Load word with addr_ok on cycle 2 and data_ok on cycle 4.
  task automatic test_load_word();
    logic exp_req   [1:4];
    logic exp_stall [1:4];
    exp_req   = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_stall = '{1'b1, 1'b1, 1'b1, 1'b0};
    mem_read_flag_in = 1'b1;
    mem_sel_in       = 4'hF;
    address_in       = 32'h8000_0014;
    for (int c = 1; c <= 4; c++) begin
      data_addr_ok = (c == 2);
      data_data_ok = (c == 4);
      data_rdata   = (c == 4) ? 32'hDEAD_BEEF : 32'h0;
      smp();
      total++; if (data_req !== exp_req[c]) begin bad++; $display("FAIL lw_req_c%0d got=%0b want=%0b", c, data_req, exp_req[c]); end
      total++; if (stall_request !== exp_stall[c]) begin bad++; $display("FAIL lw_stall_c%0d got=%0b want=%0b", c, stall_request, exp_stall[c]); end
      if (c == 1) begin
        total++; if (data_addr !== 32'h8000_0014) begin bad++; $display("FAIL lw_addr got=%h want=80000014", data_addr); end
        total++; if (data_wr !== 1'b0) begin bad++; $display("FAIL lw_wr got=%0b want=0", data_wr); end
        total++; if (data_be !== 4'hF) begin bad++; $display("FAIL lw_be got=%h want=f", data_be); end
      end
      if (c == 4) begin
        total++; if (ram_read_data_out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_rdata got=%h want=deadbeef", ram_read_data_out); end
      end
      step();
    end
    clear_inputs();
    smp();
    total++; if (ram_read_data_out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_rdata_hold got=%h want=deadbeef", ram_read_data_out); end
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL lw_idle_req got=%0b want=0", data_req); end
    step();
  endtask

  // Byte stores to each lane on a zero-wait bus, back to back.
  task automatic test_store_bytes();
    logic [3:0]  exp_be    [4];
    logic [31:0] exp_wdata [4];
    exp_be    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_wdata = '{32'h0000_00AB, 32'h0000_AB00, 32'h00AB_0000, 32'hAB00_0000};
    for (int i = 0; i < 4; i++) begin
      mem_write_flag_in = 1'b1;
      address_in        = 32'h0000_1000 + i;
      write_data_in     = 32'h0000_00AB;
      mem_sel_in        = exp_be[i];
      data_addr_ok      = 1'b1;
      data_data_ok      = 1'b0;
      smp();
      total++; if (data_wr !== 1'b1) begin bad++; $display("FAIL sb%0d_wr got=%0b want=1", i, data_wr); end
      total++; if (data_be !== exp_be[i]) begin bad++; $display("FAIL sb%0d_be got=%b want=%b", i, data_be, exp_be[i]); end
      total++; if (data_addr !== 32'h0000_1000) begin bad++; $display("FAIL sb%0d_addr got=%h want=00001000", i, data_addr); end
      total++; if (data_wdata !== exp_wdata[i]) begin bad++; $display("FAIL sb%0d_wdata got=%h want=%h", i, data_wdata, exp_wdata[i]); end
      total++; if (data_req !== 1'b1) begin bad++; $display("FAIL sb%0d_req got=%0b want=1", i, data_req); end
      total++; if (stall_request !== 1'b1) begin bad++; $display("FAIL sb%0d_stall1 got=%0b want=1", i, stall_request); end
      step();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b1;
      smp();
      total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL sb%0d_stall2 got=%0b want=0", i, stall_request); end
      total++; if (data_req !== 1'b0) begin bad++; $display("FAIL sb%0d_req2 got=%0b want=0", i, data_req); end
      step();
    end
    clear_inputs();
    smp();
    total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL sb_after_stall got=%0b want=0", stall_request); end
    step();
  endtask

  // Pipeline stall on the data_ok cycle parks the controller in DONE.
  task automatic test_stall_hold();
    mem_read_flag_in = 1'b1;
    mem_sel_in       = 4'hF;
    address_in       = 32'h0000_0040;
    data_addr_ok     = 1'b1;
    smp();
    total++; if (data_req !== 1'b1) begin bad++; $display("FAIL sh_req got=%0b want=1", data_req); end
    step();
    data_addr_ok        = 1'b0;
    data_data_ok        = 1'b1;
    data_rdata          = 32'h1234_5678;
    stall_current_stage = 1'b1;
    smp();
    total++; if (ram_read_data_out !== 32'h1234_5678) begin bad++; $display("FAIL sh_rdata_ok got=%h want=12345678", ram_read_data_out); end
    total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL sh_stall_ok got=%0b want=0", stall_request); end
    step();
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    for (int c = 0; c < 4; c++) begin
      stall_current_stage = (c < 3);
      smp();
      total++; if (data_req !== 1'b0) begin bad++; $display("FAIL sh_done%0d_req got=%0b want=0", c, data_req); end
      total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL sh_done%0d_stall got=%0b want=0", c, stall_request); end
      total++; if (ram_read_data_out !== 32'h1234_5678) begin bad++; $display("FAIL sh_done%0d_rdata got=%h want=12345678", c, ram_read_data_out); end
      step();
    end
    clear_inputs();
    smp();
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL sh_idle_req got=%0b want=0", data_req); end
    total++; if (ram_read_data_out !== 32'h1234_5678) begin bad++; $display("FAIL sh_idle_rdata got=%h want=12345678", ram_read_data_out); end
    step();
  endtask

  // Flush while the address phase is still pending.
  task automatic test_flush_req();
    mem_read_flag_in = 1'b1;
    mem_sel_in       = 4'hF;
    address_in       = 32'h0000_0080;
    smp();
    total++; if (data_req !== 1'b1) begin bad++; $display("FAIL fr_req1 got=%0b want=1", data_req); end
    step();
    flush = 1'b1;
    smp();
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL fr_req_flush got=%0b want=0", data_req); end
    total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL fr_stall_flush got=%0b want=0", stall_request); end
    step();
    clear_inputs();
    smp();
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL fr_req_idle got=%0b want=0", data_req); end
    step();
    mem_read_flag_in = 1'b1;
    mem_sel_in       = 4'hF;
    address_in       = 32'h0000_0084;
    data_addr_ok     = 1'b1;
    smp();
    total++; if (data_req !== 1'b1) begin bad++; $display("FAIL fr_new_req got=%0b want=1", data_req); end
    step();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFE_F00D;
    smp();
    total++; if (ram_read_data_out !== 32'hCAFE_F00D) begin bad++; $display("FAIL fr_new_rdata got=%h want=cafef00d", ram_read_data_out); end
    total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL fr_new_stall got=%0b want=0", stall_request); end
    step();
    clear_inputs();
  endtask

  // Flush after acceptance: the stale response must drain first.
  task automatic test_flush_data();
    mem_read_flag_in = 1'b1;
    mem_sel_in       = 4'hF;
    address_in       = 32'h0000_0100;
    data_addr_ok     = 1'b1;
    step();
    data_addr_ok = 1'b0;
    flush        = 1'b1;
    smp();
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL fd_req_flush got=%0b want=0", data_req); end
    total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL fd_stall_flush got=%0b want=0", stall_request); end
    step();
    flush      = 1'b0;
    address_in = 32'h0000_0200;
    data_addr_ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      data_data_ok = (c == 2);
      data_rdata   = (c == 2) ? 32'hBAD0_BAD0 : 32'h0;
      smp();
      total++; if (data_req !== 1'b0) begin bad++; $display("FAIL fd_cancel%0d_req got=%0b want=0", c, data_req); end
      total++; if (stall_request !== 1'b1) begin bad++; $display("FAIL fd_cancel%0d_stall got=%0b want=1", c, stall_request); end
      total++; if (ram_read_data_out !== 32'hCAFE_F00D) begin bad++; $display("FAIL fd_cancel%0d_rdata got=%h want=cafef00d", c, ram_read_data_out); end
      step();
    end
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    smp();
    total++; if (data_req !== 1'b1) begin bad++; $display("FAIL fd_new_req got=%0b want=1", data_req); end
    total++; if (ram_read_data_out !== 32'hCAFE_F00D) begin bad++; $display("FAIL fd_new_rdata_old got=%h want=cafef00d", ram_read_data_out); end
    step();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h55AA_55AA;
    smp();
    total++; if (ram_read_data_out !== 32'h55AA_55AA) begin bad++; $display("FAIL fd_new_rdata got=%h want=55aa55aa", ram_read_data_out); end
    total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL fd_new_stall got=%0b want=0", stall_request); end
    step();
    clear_inputs();
    smp();
    total++; if (ram_read_data_out !== 32'h55AA_55AA) begin bad++; $display("FAIL fd_hold_rdata got=%h want=55aa55aa", ram_read_data_out); end
    step();
  endtask

  // Asynchronous reset while waiting in DATA.
  task automatic test_reset_in_data();
    mem_read_flag_in = 1'b1;
    mem_sel_in       = 4'hF;
    address_in       = 32'h0000_0300;
    data_addr_ok     = 1'b1;
    step();
    data_addr_ok = 1'b0;
    #1;
    total++; if (stall_request !== 1'b1) begin bad++; $display("FAIL rd_stall_pre got=%0b want=1", stall_request); end
    rst = 1'b0;
    #1;
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL rd_req_async got=%0b want=0", data_req); end
    total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL rd_stall_async got=%0b want=0", stall_request); end
    total++; if (ram_read_data_out !== 32'h0) begin bad++; $display("FAIL rd_rdata_async got=%h want=00000000", ram_read_data_out); end
    data_data_ok = 1'b1;
    data_rdata   = 32'h7777_7777;
    step();
    smp();
    total++; if (ram_read_data_out !== 32'h0) begin bad++; $display("FAIL rd_rdata_inrst got=%h want=00000000", ram_read_data_out); end
    step();
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    rst          = 1'b1;
    data_addr_ok = 1'b1;
    smp();
    total++; if (data_req !== 1'b1) begin bad++; $display("FAIL rd_post_req got=%0b want=1", data_req); end
    total++; if (data_addr !== 32'h0000_0300) begin bad++; $display("FAIL rd_post_addr got=%h want=00000300", data_addr); end
    step();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h0F0F_0F0F;
    smp();
    total++; if (ram_read_data_out !== 32'h0F0F_0F0F) begin bad++; $display("FAIL rd_post_rdata got=%h want=0f0f0f0f", ram_read_data_out); end
    total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL rd_post_stall got=%0b want=0", stall_request); end
    step();
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_word();
    test_store_bytes();
    test_stall_hold();
    test_flush_req();
    test_flush_data();
    test_reset_in_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
